// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI flash responder: FSM states, opcodes,
// address width and the debug view exported on the bus interface.
package qspi_pkg;

   localparam int ADDR_W = 24;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_QREAD = 8'h6B;
   localparam logic [7:0] OP_RDID  = 8'h9F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_ID,
      ST_IGNORE
   } state_t;

   // Debug view: FSM state plus the synchronized IO pad inputs.
   typedef struct packed {
      state_t     state;
      logic [3:0] io_sync;
   } dbg_t;

endpackage

// File: rtl/qspi_flash_responder_if.sv
// Pad and backing-store signals of the QSPI flash responder.
//
// Backing-store handshake: the responder raises mem_rd for exactly one mclk
// with mem_addr stable in that cycle; the store answers with a one-mclk
// mem_valid pulse carrying mem_rdata no later than 2 mclk after mem_rd.
// There is no back-pressure; a byte whose mem_valid never came reads as 0xFF.
interface qspi_flash_responder_if;
   import qspi_pkg::*;

   logic              sck_in;
   logic              cs_n_in;
   logic [3:0]        io_in;
   logic [3:0]        io_out;
   logic [3:0]        io_oe;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_rdata;
   logic              mem_valid;
   logic              busy;
   logic              cmd_err;
   dbg_t              dbg;

   modport slave (
      input  sck_in, cs_n_in, io_in, mem_rdata, mem_valid,
      output io_out, io_oe, mem_addr, mem_rd, busy, cmd_err, dbg
   );

   modport master (
      output sck_in, cs_n_in, io_in, mem_rdata, mem_valid,
      input  io_out, io_oe, mem_addr, mem_rd, busy, cmd_err, dbg
   );
endinterface

// File: rtl/qspi_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with one-mclk pulses on
// rising and falling edges of the synchronized value.
module qspi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);
   logic ff1_q, ff2_q, ff3_q;

   // Two synchronizing stages plus one history stage for edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ff1_q <= RST_VAL;
         ff2_q <= RST_VAL;
         ff3_q <= RST_VAL;
      end else begin
         ff1_q <= d_i;
         ff2_q <= ff1_q;
         ff3_q <= ff2_q;
      end
   end

   assign rise_o = ff2_q & ~ff3_q;
   assign fall_o = ~ff2_q & ff3_q;
endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash responder: decodes READ (0x03), QUAD OUTPUT READ (0x6B) and
// READ ID (0x9F) from an SPI mode-0 initiator, oversampled on mclk.
module qspi_flash_responder #(
   parameter int          DUMMY_CYCLES = 8,
   parameter logic [23:0] ID_VALUE     = 24'h20BA18
) (
   input  logic                   mclk,
   input  logic                   RESET,
   qspi_flash_responder_if.slave  bus
);
   import qspi_pkg::*;

   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic [3:0] io_s1_q, io_s2_q;

   state_t            state_q, state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [22:0]       addr_sh_q, addr_sh_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic [7:0]        next_q, next_d;
   logic              next_vld_q, next_vld_d;
   logic [7:0]        byte_q, byte_d;
   logic [3:0]        io_out_q, io_out_d;
   logic [3:0]        io_oe_q, io_oe_d;
   logic              cmd_err_q, cmd_err_d;
   logic [7:0]        cur_byte;

   qspi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
      .clk_i(mclk), .rst_i(RESET), .d_i(bus.sck_in),
      .rise_o(sck_rise), .fall_o(sck_fall)
   );

   qspi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk_i(mclk), .rst_i(RESET), .d_i(bus.cs_n_in),
      .rise_o(cs_rise), .fall_o(cs_fall)
   );

   // IO pads get the same two-stage delay as sck so data lines up with edges.
   always_ff @(posedge mclk or posedge RESET) begin
      if (RESET) begin
         io_s1_q <= 4'h0;
         io_s2_q <= 4'h0;
      end else begin
         io_s1_q <= bus.io_in;
         io_s2_q <= io_s1_q;
      end
   end

   // Prefetched byte if it arrived, otherwise the all-ones filler.
   assign cur_byte = next_vld_q ? next_q : 8'hFF;

   // FSM and datapath register bank.
   always_ff @(posedge mclk or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         cmd_q      <= 8'h00;
         cnt_q      <= 8'h00;
         addr_sh_q  <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         next_q     <= 8'h00;
         next_vld_q <= 1'b0;
         byte_q     <= 8'h00;
         io_out_q   <= 4'h0;
         io_oe_q    <= 4'h0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         cnt_q      <= cnt_d;
         addr_sh_q  <= addr_sh_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         next_q     <= next_d;
         next_vld_q <= next_vld_d;
         byte_q     <= byte_d;
         io_out_q   <= io_out_d;
         io_oe_q    <= io_oe_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   // Next-state logic: chip-select edges take priority over any SCK edge.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      cnt_d      = cnt_q;
      addr_sh_d  = addr_sh_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = 1'b0;
      next_d     = next_q;
      next_vld_d = next_vld_q;
      byte_d     = byte_q;
      io_out_d   = io_out_q;
      cmd_err_d  = 1'b0;

      if (cs_rise) begin
         state_d  = ST_IDLE;
         io_out_d = 4'h0;
      end else if (cs_fall) begin
         state_d    = ST_CMD;
         cnt_d      = 8'h00;
         cmd_d      = 8'h00;
         next_vld_d = 1'b0;
         io_out_d   = 4'h0;
      end else begin
         case (state_q)
            ST_CMD: if (sck_rise) begin
               cmd_d = {cmd_q[6:0], io_s2_q[0]};
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'd7) begin
                  cnt_d = 8'h00;
                  if (cmd_d == OP_READ || cmd_d == OP_QREAD) begin
                     state_d = ST_ADDR;
                  end else if (cmd_d == OP_RDID) begin
                     state_d = ST_ID;
                  end else begin
                     state_d   = ST_IGNORE;
                     cmd_err_d = 1'b1;
                  end
               end
            end
            ST_ADDR: if (sck_rise) begin
               addr_sh_d = {addr_sh_q[21:0], io_s2_q[0]};
               cnt_d     = cnt_q + 8'd1;
               if (cnt_q == 8'd23) begin
                  cnt_d      = 8'h00;
                  mem_addr_d = {addr_sh_q, io_s2_q[0]};
                  mem_rd_d   = 1'b1;
                  next_vld_d = 1'b0;
                  state_d    = (cmd_q == OP_QREAD && DUMMY_CYCLES != 0) ? ST_DUMMY : ST_DATA;
               end
            end
            ST_DUMMY: if (sck_rise) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == DUMMY_LAST) begin
                  cnt_d   = 8'h00;
                  state_d = ST_DATA;
               end
            end
            ST_DATA: if (sck_fall) begin
               // First bit/nibble of a byte: latch it and prefetch the next one.
               if (cnt_q[2:0] == 3'd0) begin
                  byte_d     = cur_byte;
                  mem_addr_d = mem_addr_q + 24'd1;
                  mem_rd_d   = 1'b1;
                  next_vld_d = 1'b0;
               end
               if (cmd_q == OP_QREAD) begin
                  io_out_d = (cnt_q[0] == 1'b0) ? byte_d[7:4] : byte_d[3:0];
                  cnt_d    = {7'd0, ~cnt_q[0]};
               end else begin
                  io_out_d = {2'b00, byte_d[3'd7 - cnt_q[2:0]], 1'b0};
                  cnt_d    = {5'd0, cnt_q[2:0] + 3'd1};
               end
            end
            ST_ID: if (sck_fall) begin
               if (cnt_q < 8'd24) begin
                  io_out_d = {2'b00, ID_VALUE[5'd23 - cnt_q[4:0]], 1'b0};
                  cnt_d    = cnt_q + 8'd1;
               end else begin
                  io_out_d = 4'h0;
               end
            end
            default: ;
         endcase
      end

      if (bus.mem_valid) begin
         next_d     = bus.mem_rdata;
         next_vld_d = 1'b1;
      end

      case (state_d)
         ST_DATA: io_oe_d = (cmd_q == OP_QREAD) ? 4'hF : 4'h2;
         ST_ID:   io_oe_d = 4'h2;
         default: io_oe_d = 4'h0;
      endcase
   end

   assign bus.io_out   = io_out_q;
   assign bus.io_oe    = io_oe_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_rd   = mem_rd_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.cmd_err  = cmd_err_q;
   assign bus.dbg      = '{state: state_q, io_sync: io_s2_q};
endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for the QSPI flash responder: an SPI mode-0 initiator model,
// a one-cycle-latency backing store and a table of read transactions.
module tb_qspi_flash_responder;
   import qspi_pkg::*;

   localparam int HALF = 8;   // mclk cycles per SCK half period

   typedef struct {
      string       name;
      logic [7:0]  op;
      logic [23:0] addr;
      int          nsck;
      logic [31:0] exp_data;
      logic [23:0] exp_a0;
      logic [23:0] exp_a1;
      logic        chk_addr;
   } vec_t;

   logic mclk;
   logic RESET;
   int   total;
   int   bad;
   int   err_cnt;

   logic [7:0]  store [logic [23:0]];
   logic [23:0] rd_log [$];
   vec_t        vecs [5];

   qspi_flash_responder_if bus ();

   qspi_flash_responder #(
      .DUMMY_CYCLES(8),
      .ID_VALUE(24'h20BA18)
   ) dut (
      .mclk(mclk),
      .RESET(RESET),
      .bus(bus)
   );

   // clock / reset
   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // backing store: answers every mem_rd one mclk later
   always @(posedge mclk) begin
      bus.mem_valid <= 1'b0;
      if (bus.mem_rd === 1'b1) begin
         bus.mem_valid <= 1'b1;
         bus.mem_rdata <= store.exists(bus.mem_addr) ? store[bus.mem_addr] : 8'h00;
         rd_log.push_back(bus.mem_addr);
      end
   end

   // cmd_err pulse counter
   always @(posedge mclk) begin
      if (bus.cmd_err === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // one SCK period; outputs sampled at the rising edge
   task automatic send_bit(input logic b, output logic [3:0] o, output logic [3:0] oe);
      bus.io_in = {3'b000, b};
      repeat (HALF) @(negedge mclk);
      bus.sck_in = 1'b1;
      o  = bus.io_out;
      oe = bus.io_oe;
      repeat (HALF) @(negedge mclk);
      bus.sck_in = 1'b0;
   endtask

   task automatic send_header(input logic [7:0] op, input logic [23:0] addr, input logic with_addr);
      logic [3:0] o, oe;
      bus.cs_n_in = 1'b0;
      repeat (4) @(negedge mclk);
      for (int i = 7; i >= 0; i--) send_bit(op[i], o, oe);
      if (with_addr)
         for (int i = 23; i >= 0; i--) send_bit(addr[i], o, oe);
   endtask

   task automatic end_txn(input string nm);
      repeat (HALF) @(negedge mclk);
      bus.cs_n_in = 1'b1;
      repeat (8) @(negedge mclk);
      check({nm, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
      check({nm, "_oe_end"}, {28'd0, bus.io_oe}, 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      logic [3:0]  o, oe, exp_oe;
      logic [31:0] got;
      logic        oe_bad, dummy_bad;
      rd_log.delete();
      send_header(v.op, v.addr, v.op != OP_RDID);
      if (v.op == OP_QREAD) begin
         dummy_bad = 1'b0;
         for (int i = 0; i < 8; i++) begin
            send_bit(1'b0, o, oe);
            if (oe !== 4'h0) dummy_bad = 1'b1;
         end
         check({v.name, "_dummy_oe"}, {31'd0, dummy_bad}, 32'd0);
      end
      exp_oe = (v.op == OP_QREAD) ? 4'hF : 4'h2;
      got    = 32'd0;
      oe_bad = 1'b0;
      for (int i = 0; i < v.nsck; i++) begin
         send_bit(1'b0, o, oe);
         if (v.op == OP_QREAD) got = {got[27:0], o};
         else                  got = {got[30:0], o[1]};
         if (oe !== exp_oe) oe_bad = 1'b1;
      end
      check({v.name, "_data"}, got, v.exp_data);
      check({v.name, "_data_oe"}, {31'd0, oe_bad}, 32'd0);
      end_txn(v.name);
      if (v.chk_addr) begin
         if (rd_log.size() < 2) begin
            check({v.name, "_rd_count"}, rd_log.size(), 32'd2);
         end else begin
            check({v.name, "_addr0"}, {8'd0, rd_log[0]}, {8'd0, v.exp_a0});
            check({v.name, "_addr1"}, {8'd0, rd_log[1]}, {8'd0, v.exp_a1});
         end
      end
   endtask

   initial begin
      logic [3:0] o, oe;
      logic       ign_oe_bad;
      int         err_base;

      total   = 0;
      bad     = 0;
      err_cnt = 0;

      store[24'h000100] = 8'hA5;
      store[24'h000101] = 8'h3C;
      store[24'hFFFFFF] = 8'h81;
      store[24'h000000] = 8'h7E;
      store[24'h000010] = 8'hC3;
      store[24'h000011] = 8'h96;

      vecs[0] = '{"rd_100",  8'h03, 24'h000100, 16, 32'h0000A53C, 24'h000100, 24'h000101, 1'b1};
      vecs[1] = '{"rd_wrap", 8'h03, 24'hFFFFFF, 16, 32'h0000817E, 24'hFFFFFF, 24'h000000, 1'b1};
      vecs[2] = '{"qrd_10",  8'h6B, 24'h000010,  4, 32'h0000C396, 24'h000010, 24'h000011, 1'b1};
      vecs[3] = '{"rdid",    8'h9F, 24'h000000, 32, 32'h20BA1800, 24'h000000, 24'h000000, 1'b0};
      vecs[4] = '{"rd_101",  8'h03, 24'h000101,  8, 32'h0000003C, 24'h000101, 24'h000102, 1'b1};

      RESET       = 1'b1;
      bus.sck_in  = 1'b0;
      bus.cs_n_in = 1'b1;
      bus.io_in   = 4'h0;
      repeat (5) @(negedge mclk);
      check("rst_io_oe",    {28'd0, bus.io_oe},  32'd0);
      check("rst_io_out",   {28'd0, bus.io_out}, 32'd0);
      check("rst_mem_addr", {8'd0, bus.mem_addr}, 32'd0);
      check("rst_mem_rd",   {31'd0, bus.mem_rd},  32'd0);
      check("rst_busy",     {31'd0, bus.busy},    32'd0);
      check("rst_cmd_err",  {31'd0, bus.cmd_err}, 32'd0);
      RESET = 1'b0;
      repeat (10) @(negedge mclk);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);
      check("no_err_valid_ops", err_cnt, 32'd0);

      // unsupported opcode: one cmd_err, outputs stay released until CS rises
      err_base   = err_cnt;
      ign_oe_bad = 1'b0;
      send_header(8'h5A, 24'h0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send_bit(i[0], o, oe);
         if (oe !== 4'h0) ign_oe_bad = 1'b1;
      end
      check("ign_busy", {31'd0, bus.busy}, 32'd1);
      check("ign_oe", {31'd0, ign_oe_bad}, 32'd0);
      end_txn("ign");
      check("ign_err_pulses", err_cnt - err_base, 32'd1);
      run_vec(vecs[3]);

      // reset in the middle of a read data phase
      send_header(8'h03, 24'h000100, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b0, o, oe);
      check("pre_rst_oe", {28'd0, oe}, 32'h2);
      check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      @(negedge mclk);
      RESET = 1'b1;
      #1;
      check("midrst_oe",   {28'd0, bus.io_oe}, 32'd0);
      check("midrst_busy", {31'd0, bus.busy},  32'd0);
      bus.cs_n_in = 1'b1;
      bus.sck_in  = 1'b0;
      repeat (6) @(negedge mclk);
      RESET = 1'b0;
      repeat (10) @(negedge mclk);
      check("postrst_idle", {31'd0, bus.busy}, 32'd0);
      run_vec(vecs[4]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
